// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between the instruction-fetch
//            requester and the load/store requester. One transaction is in
//            flight at a time. A request is captured into registers at grant,
//            held on the bus until mem_ack_i or a timeout, and a completion
//            pulse is returned to the owner. Data requests win over fetches.
// Ports    :
//   clk_i, rst_ni                       clock, async active-low reset
//   instr_req_i/addr_i/kill_i           fetch request, address, discard
//   instr_done_o/rdata_o                fetch completion pulse, read data
//   data_req_i/we_i/addr_i/wdata_i/be_i load/store request and fields
//   data_done_o/rdata_o                 load/store completion pulse, data
//   bus_err_o                           pulse with done of a timed-out access
//   mem_req_o/we_o/addr_o/wdata_o/be_o  registered memory transaction
//   mem_ack_i, mem_rdata_i              memory completion and read data
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction fetch requester
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  input  logic        instr_kill_i,
  output logic        instr_done_o,
  output logic [31:0] instr_rdata_o,
  // load/store requester
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic        data_done_o,
  output logic [31:0] data_rdata_o,
  output logic        bus_err_o,
  // memory port
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Counter is wide enough for the largest legal timeout (1023).
  localparam int unsigned c_cnt_w    = 10;
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_kill;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;

  logic               w_busy;
  logic               w_tmo;
  logic               w_end;
  logic               w_grant_d;
  logic               w_grant_i;
  logic               w_data_done;
  logic               w_instr_done;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and completion decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_busy       = 1'b0;
    w_tmo        = 1'b0;
    w_end        = 1'b0;
    w_data_done  = 1'b0;
    w_instr_done = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // Ack seen here is a stale extra ack cycle and is ignored.
        if (data_req_i) begin
          w_grant_d    = 1'b1;
          w_next_state = ST_DBUSY;
        end else if (instr_req_i && !instr_kill_i) begin
          w_grant_i    = 1'b1;
          w_next_state = ST_IBUSY;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        w_busy = 1'b1;
        // Ack on the timeout cycle wins: no bus error in that case.
        w_tmo  = !mem_ack_i && (r_cnt == c_tmo_last);
        w_end  = mem_ack_i || w_tmo;
        if (w_end) begin
          w_next_state = ST_IDLE;
        end
        if (r_state == ST_DBUSY) begin
          w_data_done = w_end;
        end else begin
          // A killed fetch completes on the bus but is never reported.
          w_instr_done = w_end && !r_kill && !instr_kill_i;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Busy-cycle counter and kill flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_kill <= 1'b0;
    end else begin
      if (w_grant_d || w_grant_i) begin
        r_cnt <= '0;
      end else if (w_busy && !w_end) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_IBUSY && !w_end) begin
        if (instr_kill_i) begin
          r_kill <= 1'b1;
        end
      end else begin
        r_kill <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction capture: fields are loaded only at grant, so requester inputs
  // are free to change while the access is in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_grant_d) begin
      r_we    <= data_we_i;
      r_addr  <= data_addr_i;
      r_wdata <= data_wdata_i;
      r_be    <= data_be_i;
    end else if (w_grant_i) begin
      r_we    <= 1'b0;
      r_addr  <= instr_addr_i;
      r_wdata <= '0;
      r_be    <= 4'hF;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Derived from state so that an asynchronous reset drops the request at once.
  assign mem_req_o     = (r_state != ST_IDLE);
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign mem_be_o      = r_be;

  assign data_done_o   = w_data_done;
  assign instr_done_o  = w_instr_done;
  assign bus_err_o     = w_tmo;
  assign data_rdata_o  = mem_rdata_i;
  assign instr_rdata_o = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: a table of hand-derived
//            per-cycle vectors, hand-written reset sequences, and a random
//            run compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, instr_kill_i, instr_done_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_we_i, data_done_o, bus_err_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_kill_i(instr_kill_i), .instr_done_o(instr_done_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_done_o(data_done_o), .data_rdata_o(data_rdata_o),
    .bus_err_o(bus_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table: one record per clock cycle (inputs + expected outputs)
  // --------------------------------------------------------------------------
  typedef struct {
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dbe;
    logic        ireq;
    logic [31:0] iaddr;
    logic        ikill, ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_ddone, e_idone, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic dreq, input logic dwe, input logic [31:0] daddr,
                   input logic [31:0] dwdata, input logic [3:0] dbe,
                   input logic ireq, input logic [31:0] iaddr, input logic ikill,
                   input logic ack, input logic [31:0] rdata,
                   input logic e_req, input logic e_we, input logic [31:0] e_addr,
                   input logic [31:0] e_wdata, input logic [3:0] e_be,
                   input logic e_ddone, input logic e_idone, input logic e_err);
    vec_t r;
    r.dreq = dreq; r.dwe = dwe; r.daddr = daddr; r.dwdata = dwdata; r.dbe = dbe;
    r.ireq = ireq; r.iaddr = iaddr; r.ikill = ikill; r.ack = ack; r.rdata = rdata;
    r.e_req = e_req; r.e_we = e_we; r.e_addr = e_addr; r.e_wdata = e_wdata;
    r.e_be = e_be; r.e_ddone = e_ddone; r.e_idone = e_idone; r.e_err = e_err;
    vecs.push_back(r);
  endtask

  task automatic fill_table();
    //  dreq we daddr  dwdata dbe   ireq iaddr  kill ack rdata          | req we addr   wdata be  dd id er
    // Load, ack on the third busy cycle
    v(1, 0, 'h100, 0,     4'hF, 0, 0,     0, 0, 0,            0, 0, 'h000, 0,     4'h0, 0, 0, 0);
    v(1, 0, 'h100, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h100, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h100, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h100, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h100, 0,     4'hF, 0, 0,     0, 1, 'hDEADBEEF,   1, 0, 'h100, 0,     4'hF, 1, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h100, 0,     4'hF, 0, 0, 0);
    // Conflict: store wins, fetch follows; ack in IDLE ignored
    v(1, 1, 'h200, 'h55,  4'h3, 1, 'h300, 0, 0, 0,            0, 0, 'h100, 0,     4'hF, 0, 0, 0);
    v(1, 1, 'h200, 'h55,  4'h3, 1, 'h300, 0, 1, 'h11,         1, 1, 'h200, 'h55,  4'h3, 1, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h300, 0, 1, 'h12,         0, 1, 'h200, 'h55,  4'h3, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h300, 0, 1, 'h13,         1, 0, 'h300, 0,     4'hF, 0, 1, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h300, 0,     4'hF, 0, 0, 0);
    // Kill pulsed mid-fetch: no done, back to IDLE after ack
    v(0, 0, 0,     0,     4'h0, 1, 'h40,  0, 0, 0,            0, 0, 'h300, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h40,  0, 0, 0,            1, 0, 'h040, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h40,  1, 0, 0,            1, 0, 'h040, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            1, 0, 'h040, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 1, 'h99,         1, 0, 'h040, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h040, 0,     4'hF, 0, 0, 0);
    // Timeout after four busy cycles
    v(1, 0, 'h500, 0,     4'hF, 0, 0,     0, 0, 0,            0, 0, 'h040, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h500, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h500, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h500, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h500, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h500, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h500, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h500, 0,     4'hF, 0, 0,     0, 0, 'h77,         1, 0, 'h500, 0,     4'hF, 1, 0, 1);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h500, 0,     4'hF, 0, 0, 0);
    // Next store accepted; requester fields change while busy
    v(1, 1, 'h600, 'hAA,  4'hC, 0, 0,     0, 0, 0,            0, 0, 'h500, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h700, 'hBB,  4'h1, 0, 0,     0, 0, 0,            1, 1, 'h600, 'hAA,  4'hC, 0, 0, 0);
    v(1, 0, 'h700, 'hBB,  4'h1, 0, 0,     0, 1, 'h5,          1, 1, 'h600, 'hAA,  4'hC, 1, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 1, 'h600, 'hAA,  4'hC, 0, 0, 0);
    // Ack on the timeout cycle: ack wins, no bus error
    v(1, 0, 'h800, 0,     4'hF, 0, 0,     0, 0, 0,            0, 1, 'h600, 'hAA,  4'hC, 0, 0, 0);
    v(1, 0, 'h800, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h800, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h800, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h800, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h800, 0,     4'hF, 0, 0,     0, 0, 0,            1, 0, 'h800, 0,     4'hF, 0, 0, 0);
    v(1, 0, 'h800, 0,     4'hF, 0, 0,     0, 1, 'hCAFE,       1, 0, 'h800, 0,     4'hF, 1, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h800, 0,     4'hF, 0, 0, 0);
    // Kill high exactly in the ack cycle
    v(0, 0, 0,     0,     4'h0, 1, 'h900, 0, 0, 0,            0, 0, 'h800, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h900, 0, 0, 0,            1, 0, 'h900, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 1, 'h900, 1, 1, 'h3,          1, 0, 'h900, 0,     4'hF, 0, 0, 0);
    v(0, 0, 0,     0,     4'h0, 0, 0,     0, 0, 0,            0, 0, 'h900, 0,     4'hF, 0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Transaction-level reference model for the random run
  // --------------------------------------------------------------------------
  bit          m_valid, m_is_data, m_killed;
  int          m_age;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        e_req, e_we, e_ddone, e_idone, e_err;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic model_reset();
    m_valid = 0; m_is_data = 0; m_killed = 0; m_age = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
  endtask

  // Computes this cycle's expected outputs from current inputs, then advances.
  task automatic model_cycle();
    bit fin, err;
    e_req = m_valid; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata; e_be = m_be;
    e_ddone = 0; e_idone = 0; e_err = 0;
    if (m_valid) begin
      err = !mem_ack_i && (m_age + 1 == TMO);
      fin = mem_ack_i || err;
      e_err   = err;
      e_ddone = m_is_data && fin;
      e_idone = !m_is_data && fin && !(m_killed || instr_kill_i);
      if (fin) m_valid = 0;
      else begin
        m_age++;
        if (!m_is_data && instr_kill_i) m_killed = 1;
      end
    end else if (data_req_i) begin
      m_valid = 1; m_is_data = 1; m_age = 0; m_killed = 0;
      m_we = data_we_i; m_addr = data_addr_i; m_wdata = data_wdata_i; m_be = data_be_i;
    end else if (instr_req_i && !instr_kill_i) begin
      m_valid = 1; m_is_data = 0; m_age = 0; m_killed = 0;
      m_we = 0; m_addr = instr_addr_i; m_wdata = 0; m_be = 4'hF;
    end
  endtask

  task automatic idle_inputs();
    data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_wdata_i = 0; data_be_i = 0;
    instr_req_i = 0; instr_addr_i = 0; instr_kill_i = 0;
    mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;
  endtask

  initial begin
    bit d_drop, i_drop;
    fill_table();
    idle_inputs();

    // Reset state, with requests and ack active to show nothing leaks out
    rst_ni = 0;
    data_req_i = 1; instr_req_i = 1; mem_ack_i = 1; data_addr_i = 'h123;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst.mem_req",   32'(mem_req_o),   0);
    chk("rst.mem_addr",  mem_addr_o,       0);
    chk("rst.mem_be",    32'(mem_be_o),    0);
    chk("rst.mem_we",    32'(mem_we_o),    0);
    chk("rst.mem_wdata", mem_wdata_o,      0);
    chk("rst.done",      32'({data_done_o, instr_done_o, bus_err_o}), 0);
    idle_inputs();
    rst_ni = 1;
    @(posedge clk_i); #1;

    // Table-driven directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      data_req_i = vecs[i].dreq; data_we_i = vecs[i].dwe; data_addr_i = vecs[i].daddr;
      data_wdata_i = vecs[i].dwdata; data_be_i = vecs[i].dbe;
      instr_req_i = vecs[i].ireq; instr_addr_i = vecs[i].iaddr;
      instr_kill_i = vecs[i].ikill; mem_ack_i = vecs[i].ack; mem_rdata_i = vecs[i].rdata;
      @(negedge clk_i);
      chk($sformatf("row%0d.mem_req", i),    32'(mem_req_o),    32'(vecs[i].e_req));
      chk($sformatf("row%0d.mem_we", i),     32'(mem_we_o),     32'(vecs[i].e_we));
      chk($sformatf("row%0d.mem_addr", i),   mem_addr_o,        vecs[i].e_addr);
      chk($sformatf("row%0d.mem_wdata", i),  mem_wdata_o,       vecs[i].e_wdata);
      chk($sformatf("row%0d.mem_be", i),     32'(mem_be_o),     32'(vecs[i].e_be));
      chk($sformatf("row%0d.data_done", i),  32'(data_done_o),  32'(vecs[i].e_ddone));
      chk($sformatf("row%0d.instr_done", i), 32'(instr_done_o), 32'(vecs[i].e_idone));
      chk($sformatf("row%0d.bus_err", i),    32'(bus_err_o),    32'(vecs[i].e_err));
      if (vecs[i].e_ddone) chk($sformatf("row%0d.data_rdata", i), data_rdata_o, vecs[i].rdata);
      if (vecs[i].e_idone) chk($sformatf("row%0d.instr_rdata", i), instr_rdata_o, vecs[i].rdata);
      @(posedge clk_i); #1;
    end
    idle_inputs();

    // Asynchronous reset in the middle of a busy data access
    data_req_i = 1; data_addr_i = 'hA0; data_be_i = 4'hF;
    @(posedge clk_i); #1;
    chk("areset.busy_before", 32'(mem_req_o), 1);
    mem_ack_i = 1;
    #2 rst_ni = 0;
    #1;
    chk("areset.mem_req",   32'(mem_req_o),   0);
    chk("areset.mem_addr",  mem_addr_o,       0);
    chk("areset.data_done", 32'(data_done_o), 0);
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i); #1;
    data_req_i = 1; data_we_i = 1; data_addr_i = 'hB00; data_wdata_i = 'h1234; data_be_i = 4'h6;
    @(posedge clk_i); #1;
    mem_ack_i = 1;
    @(negedge clk_i);
    chk("areset.after.mem_addr",  mem_addr_o,        'hB00);
    chk("areset.after.mem_wdata", mem_wdata_o,       'h1234);
    chk("areset.after.data_done", 32'(data_done_o),  1);
    @(posedge clk_i); #1;
    idle_inputs();

    // Randomized run against the reference model
    do_reset();
    model_reset();
    d_drop = 0; i_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (d_drop) begin
        data_req_i = 0; d_drop = 0;
      end else if (!data_req_i && ($urandom % 4 == 0)) begin
        data_req_i = 1; data_we_i = 1'($urandom); data_addr_i = $urandom;
        data_wdata_i = $urandom; data_be_i = 4'($urandom);
      end
      if (i_drop) begin
        instr_req_i = 0; i_drop = 0;
      end else if (!instr_req_i && ($urandom % 3 == 0)) begin
        instr_req_i = 1; instr_addr_i = $urandom;
      end
      instr_kill_i = instr_req_i && ($urandom % 12 == 0);
      if (instr_kill_i) i_drop = 1;
      mem_ack_i = ($urandom % 3 == 0);
      mem_rdata_i = $urandom;
      @(negedge clk_i);
      model_cycle();
      chk("rnd.mem_req",    32'(mem_req_o),    32'(e_req));
      chk("rnd.mem_we",     32'(mem_we_o),     32'(e_we));
      chk("rnd.mem_addr",   mem_addr_o,        e_addr);
      chk("rnd.mem_wdata",  mem_wdata_o,       e_wdata);
      chk("rnd.mem_be",     32'(mem_be_o),     32'(e_be));
      chk("rnd.data_done",  32'(data_done_o),  32'(e_ddone));
      chk("rnd.instr_done", 32'(instr_done_o), 32'(e_idone));
      chk("rnd.bus_err",    32'(bus_err_o),    32'(e_err));
      if (e_ddone) chk("rnd.data_rdata", data_rdata_o, mem_rdata_i);
      if (e_idone) chk("rnd.instr_rdata", instr_rdata_o, mem_rdata_i);
      if (e_ddone) d_drop = 1;
      if (e_idone) i_drop = 1;
      @(posedge clk_i); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the data (load/store) requester, one transaction in flight at a time. Each request is captured into registers at grant, the transaction is held on the memory bus until acknowledged or timed out, and a completion pulse is returned to the owner. `data_done_o` is the `mem_done` input of the hazard unit, which holds E/M/WB stalled while a load/store is outstanding.

## Interface
- `TIMEOUT_CYC`, default 64: cycles in a busy state without `mem_ack_i` before the transaction is abandoned; legal range 1..1023.
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1: fetch request, level, held until `instr_done_o`.
- `instr_addr_i` in 32: fetch address.
- `instr_kill_i` in 1: discard the outstanding or pending fetch (wrong branch).
- `instr_done_o` out 1: fetch complete pulse; rdata valid this cycle.
- `instr_rdata_o` out 32: fetch data, equals `mem_rdata_i`.
- `data_req_i` in 1: load/store request, level, held until `data_done_o`.
- `data_we_i` in 1: 1 = store.
- `data_addr_i` in 32, `data_wdata_i` in 32, `data_be_i` in 4: store/load address, data, byte enables.
- `data_done_o` out 1: load/store complete pulse.
- `data_rdata_o` out 32: load data, equals `mem_rdata_i`.
- `bus_err_o` out 1: one-cycle pulse, coincident with the done pulse of a timed-out transaction.
- `mem_req_o` out 1: transaction valid on bus.
- `mem_we_o` out 1, `mem_addr_o` out 32, `mem_wdata_o` out 32, `mem_be_o` out 4: registered transaction fields.
- `mem_ack_i` in 1: memory completed the current transaction; `mem_rdata_i` valid.
- `mem_rdata_i` in 32: read data.

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - If `data_req_i`, go to DBUSY. Latch `data_we_i`, `data_addr_i`, `data_wdata_i`, `data_be_i`.
  - Else if `instr_req_i & !instr_kill_i`, go to IBUSY. Latch `instr_addr_i`, we=0, be=4'hF, wdata=0.
  - Data always wins. The fetch is the younger instruction and is stalled anyway while a load/store is pending.
- IBUSY/DBUSY:
  - `mem_req_o`=1. Bus fields are the latched registers; requester inputs are ignored.
  - On `mem_ack_i`, return to IDLE and assert the owner's done signal combinationally in the same cycle.
- Kill:
  - `instr_kill_i` in IBUSY sets a kill flag.
  - On ack with the flag set (or with kill high in the ack cycle), `instr_done_o` stays 0.
  - The flag clears on leaving IBUSY. The bus transaction itself is never aborted.
- Timeout:
  - A counter clears on entry to a busy state and increments each busy cycle without ack.
  - At `TIMEOUT_CYC`, return to IDLE and pulse the owner's done and `bus_err_o`. A killed fetch gets no done, but `bus_err_o` still pulses.
  - If ack and timeout land on the same cycle, the ack wins and `bus_err_o`=0.
- The done pulse requires the requester to either drop or change its request on the following cycle. The arbiter samples again in the IDLE cycle after done.
- `data_done_o` and `instr_done_o` are never high in the same cycle.

## Timing
- Reset (async, any state): state=IDLE, counter=0, kill flag=0.
  - All outputs 0: `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`, done, `bus_err_o`.
  - Reset mid-transaction drops it silently; no done.
- Request sampled in IDLE at cycle 0 → `mem_req_o`=1 from cycle 1.
- Earliest ack is cycle 1, giving done in cycle 1. Minimum 2 cycles per access; back-to-back accesses every 2 cycles (IDLE gap cycle between).
- Memory holding ack high for several cycles: only the first ack cycle counts. The extra cycle lands in IDLE and is ignored.
- Ack in IDLE is ignored.
- `instr_rdata_o`/`data_rdata_o` are combinational from `mem_rdata_i`; only meaningful with the matching done.

## Test plan
- Load: `data_req_i`=1, we=0, addr=0x100, be=F at cycle 0; ack at cycle 3 with rdata=0xDEADBEEF → `mem_req_o` high cycles 1–3, `mem_addr_o`=0x100, `data_done_o` and `data_rdata_o`=0xDEADBEEF at cycle 3 only.
- Conflict: `instr_req_i` and `data_req_i` (store, addr 0x200, wdata 0x55, be 4'b0011) both rise at cycle 0, 1-cycle ack memory → store issued first (`mem_we_o`=1, `mem_be_o`=0011), `data_done_o` cycle 1; fetch granted cycle 2, `instr_done_o` cycle 3.
- Kill: fetch at 0x40 granted, `instr_kill_i` pulsed in cycle 2, ack cycle 4 → `instr_done_o` never asserts; state returns to IDLE at cycle 5.
- Timeout with `TIMEOUT_CYC`=4, no ack on a load → `data_done_o` and `bus_err_o` pulse together exactly 4 busy cycles after grant; next request is accepted normally.
- `rst_ni` low during DBUSY → `mem_req_o` falls immediately (async), no done; after release, new request served normally.
- Input change after grant: `data_addr_i` changes while DBUSY → `mem_addr_o` holds the latched value.
